// File: rtl/stream_differencer_if.sv
// stream_differencer_if
//   Bundles the upstream (total) and downstream (increment) handshakes of
//   the stream differencer.
//   slave  : the differencer itself (consumes i_*, drives o_*)
//   master : the environment around it (drives i_*, observes o_*)
//   Signals: i_VALID/o_READY/i_DATA_IN   upstream sample handshake
//            o_VALID/i_READY/o_DATA_OUT  downstream difference handshake
//            o_PRIMED                    history fully loaded
interface stream_differencer_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  i_VALID;
   logic                  o_READY;
   logic [DATA_WIDTH-1:0] i_DATA_IN;
   logic                  o_VALID;
   logic                  i_READY;
   logic [DATA_WIDTH-1:0] o_DATA_OUT;
   logic                  o_PRIMED;

   modport slave (
      input  i_VALID, i_DATA_IN, i_READY,
      output o_READY, o_VALID, o_DATA_OUT, o_PRIMED
   );

   modport master (
      output i_VALID, i_DATA_IN, i_READY,
      input  o_READY, o_VALID, o_DATA_OUT, o_PRIMED
   );
endinterface

// File: rtl/stream_differencer.sv
// stream_differencer
//   Turns a stream of running totals back into increments:
//   y[n] = x[n] - x[n-DELAY] (mod 2^DATA_WIDTH). History starts at zero, so
//   the first DELAY outputs equal their inputs, matching an accumulator that
//   starts from zero. Single registered output stage with valid/ready.
//   Ports:
//     i_CLK    clock, rising edge
//     i_RESET  asynchronous active-high reset
//     i_CLEAR  synchronous clear of history/output/prime state (wins over accept)
//     strm     stream_differencer_if.slave handshake bundle
//   Parameters: DATA_WIDTH sample width; DELAY differential delay, 1..16.
module stream_differencer #(
   parameter int DATA_WIDTH = 32,
   parameter int DELAY      = 1
) (
   input  logic                 i_CLK,
   input  logic                 i_RESET,
   input  logic                 i_CLEAR,
   stream_differencer_if.slave  strm
);
   localparam int            CW   = $clog2(DELAY + 1);
   localparam logic [CW-1:0] FULL = CW'(DELAY);

   logic [DATA_WIDTH-1:0] hist [DELAY];
   logic [CW-1:0]         cnt;
   logic                  vld;
   logic [DATA_WIDTH-1:0] dout;
   logic                  primed;
   logic                  rdy;
   logic                  accept;
   logic                  drain;

   // Single-entry stage: refill in the same cycle it drains, so no bubbles.
   assign rdy    = !vld | strm.i_READY;
   assign accept = strm.i_VALID & rdy;
   assign drain  = vld & strm.i_READY;

   assign strm.o_READY    = rdy;
   assign strm.o_VALID    = vld;
   assign strm.o_DATA_OUT = dout;
   assign strm.o_PRIMED   = primed;

   always_ff @(posedge i_CLK or posedge i_RESET) begin
      if (i_RESET) begin
         for (int k = 0; k < DELAY; k++) hist[k] <= '0;
         cnt    <= '0;
         vld    <= 1'b0;
         dout   <= '0;
         primed <= 1'b0;
      end else if (i_CLEAR) begin
         // Any sample offered this cycle is dropped.
         for (int k = 0; k < DELAY; k++) hist[k] <= '0;
         cnt    <= '0;
         vld    <= 1'b0;
         dout   <= '0;
         primed <= 1'b0;
      end else if (accept) begin
         // Plain modular subtraction: wrapped totals give the true increment.
         dout    <= strm.i_DATA_IN - hist[DELAY-1];
         vld     <= 1'b1;
         hist[0] <= strm.i_DATA_IN;
         for (int k = 1; k < DELAY; k++) hist[k] <= hist[k-1];
         if (cnt != FULL) cnt <= cnt + 1'b1;
         // Primed once this accept brings the count to DELAY.
         primed  <= (cnt >= FULL - 1'b1);
      end else if (drain) begin
         vld <= 1'b0;
      end
   end
endmodule
